// File: rtl/wb_trace_fifo_if.sv
// Trace capture bus and valid/ready consumer handshake for wb_trace_fifo.
// master = producer/consumer side, slave = the FIFO itself.
interface wb_trace_fifo_if #(
  parameter int unsigned AW = 4
);
  logic [31:0] in_pc;
  logic        in_wen;
  logic [4:0]  in_wnum;
  logic [31:0] in_wdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_wnum;
  logic [31:0] out_wdata;
  logic [AW:0] count;
  logic        overflow;
  logic [15:0] drop_cnt;

  modport master (
    output in_pc, in_wen, in_wnum, in_wdata, flush, out_ready,
    input  out_valid, out_pc, out_wnum, out_wdata, count, overflow, drop_cnt
  );

  modport slave (
    input  in_pc, in_wen, in_wnum, in_wdata, flush, out_ready,
    output out_valid, out_pc, out_wnum, out_wdata, count, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// First-word-fall-through FIFO for the retired-instruction writeback trace,
// with sticky, saturating accounting of records lost while full.
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic             clk,
  input logic             reset,
  wb_trace_fifo_if.slave  bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic   capture, pop, push, drop, full, out_valid, wr_en;
  entry_t wr_entry, head;

  always_comb begin
    capture   = bus.in_wen & (bus.in_wnum != 5'd0);
    out_valid = (count_q != '0);
    full      = (count_q == FULL_CNT);
    pop       = out_valid & bus.out_ready;
    push      = capture & (~full | pop);
    drop      = capture & full & ~pop;
    wr_entry  = '{pc: bus.in_pc, wnum: bus.in_wnum, wdata: bus.in_wdata};

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;

    // Flush discards the same-cycle capture without counting it as a drop.
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_en = push;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    bus.out_valid = out_valid;
    bus.out_pc    = out_valid ? head.pc    : '0;
    bus.out_wnum  = out_valid ? head.wnum  : '0;
    bus.out_wdata = out_valid ? head.wdata : '0;
    bus.count     = count_q;
    bus.overflow  = overflow_q;
    bus.drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_wb_trace_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_trace_fifo_if #(.AW(AW)) bus ();
  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  typedef struct packed {
    logic        rst, fl, wen, rdy;
    logic [4:0]  wnum;
    logic [31:0] pc, wdata;
    logic        e_valid;
    logic [4:0]  e_count;
    logic [31:0] e_pc;
    logic [4:0]  e_wnum;
    logic [31:0] e_wdata;
  } vec_t;

  rec_t        mq[$];
  logic        m_ovf;
  int unsigned m_drop;
  int          checks   = 0;
  int          failures = 0;
  vec_t        tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic wen, input logic [4:0] wnum,
                       input logic [31:0] pc, input logic [31:0] wdata, input logic rdy);
    reset = rst; bus.flush = fl; bus.in_wen = wen; bus.in_wnum = wnum;
    bus.in_pc = pc; bus.in_wdata = wdata; bus.out_ready = rdy;
  endtask

  task automatic compare_model();
    rec_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("model_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("model_count", 32'(bus.count), 32'(mq.size()));
    chk("model_pc", bus.out_pc, h.pc);
    chk("model_wnum", 32'(bus.out_wnum), 32'(h.wnum));
    chk("model_wdata", bus.out_wdata, h.wdata);
    chk("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("model_drop_cnt", 32'(bus.drop_cnt), m_drop);
  endtask

  // Advances the reference model on the driven inputs, clocks once, compares.
  task automatic step();
    int  sz;
    bit  pop, cap;
    sz  = mq.size();
    pop = (sz != 0) && bus.out_ready;
    cap = bus.in_wen && (bus.in_wnum != 5'd0);
    if (reset) begin
      mq.delete(); m_ovf = 1'b0; m_drop = 0;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (sz < DEPTH || pop) mq.push_back('{pc: bus.in_pc, wnum: bus.in_wnum, wdata: bus.in_wdata});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  function automatic vec_t mk(input logic rst, input logic wen, input logic [4:0] wnum,
                              input logic [31:0] pc, input logic [31:0] wdata, input logic rdy,
                              input logic ev, input logic [4:0] ec, input logic [31:0] epc,
                              input logic [4:0] ewn, input logic [31:0] ewd);
    vec_t v;
    v.rst = rst; v.fl = 1'b0; v.wen = wen; v.rdy = rdy; v.wnum = wnum; v.pc = pc; v.wdata = wdata;
    v.e_valid = ev; v.e_count = ec; v.e_pc = epc; v.e_wnum = ewn; v.e_wdata = ewd;
    return v;
  endfunction

  initial begin
    m_ovf = 1'b0; m_drop = 0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 1, 1, 32'hBFC00000, 32'h11, 0, 1, 1, 32'hBFC00000, 1, 32'h11);
    tbl[2] = mk(0, 1, 2, 32'hBFC00004, 32'h22, 0, 1, 2, 32'hBFC00000, 1, 32'h11);
    tbl[3] = mk(0, 1, 3, 32'hBFC00008, 32'h33, 0, 1, 3, 32'hBFC00000, 1, 32'h11);
    tbl[4] = mk(0, 0, 0, 0, 0, 0, 1, 3, 32'hBFC00000, 1, 32'h11);
    tbl[5] = mk(0, 0, 0, 0, 0, 1, 1, 2, 32'hBFC00004, 2, 32'h22);
    tbl[6] = mk(0, 0, 0, 0, 0, 1, 1, 1, 32'hBFC00008, 3, 32'h33);
    tbl[7] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 8; i < 18; i++)
      tbl[i] = mk(0, 1, 0, 32'h9000 + 32'(i), 32'hABCD, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].wen, tbl[i].wnum, tbl[i].pc, tbl[i].wdata, tbl[i].rdy);
      step();
      chk("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].e_valid));
      chk("tbl_count", 32'(bus.count), 32'(tbl[i].e_count));
      chk("tbl_pc", bus.out_pc, tbl[i].e_pc);
      chk("tbl_wnum", 32'(bus.out_wnum), 32'(tbl[i].e_wnum));
      chk("tbl_wdata", bus.out_wdata, tbl[i].e_wdata);
    end
    chk("r0_overflow", 32'(bus.overflow), 32'd0);
    chk("r0_drop_cnt", 32'(bus.drop_cnt), 32'd0);

    // Overflow: 20 captures into a 16-deep FIFO, then full + capture + pop.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 5'((i % 31) + 1), 32'h1000 + 32'(4 * i), 32'(i), 0);
      step();
    end
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd4);
    drive(0, 0, 1, 5'd7, 32'hDEAD0000, 32'h77, 1); step();
    chk("fullpop_count", 32'(bus.count), 32'd16);
    chk("fullpop_drop_cnt", 32'(bus.drop_cnt), 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("drain_pc", bus.out_pc, (i < 15) ? 32'h1000 + 32'(4 * (i + 1)) : 32'hDEAD0000);
      drive(0, 0, 0, 0, 0, 0, 1); step();
    end
    chk("drain_empty", 32'(bus.count), 32'd0);

    // Streaming with out_ready held high: one-cycle lag, pointers wrap twice.
    drive(1, 0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 1, 5'd9, 32'h2000 + 32'(4 * i), 32'h5000 + 32'(i), 1);
      step();
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_pc", bus.out_pc, 32'h2000 + 32'(4 * i));
    end

    // Flush with a same-cycle capture, then reset mid-stream.
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 25; i++) begin
      drive(0, 0, 1, 5'd4, 32'h3000 + 32'(4 * i), 32'(i), 0); step();
    end
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); step();
    end
    chk("pre_flush_count", 32'(bus.count), 32'd5);
    drive(0, 1, 1, 5'd6, 32'h4000, 32'h66, 0); step();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_overflow", 32'(bus.overflow), 32'd1);
    chk("flush_drop_cnt", 32'(bus.drop_cnt), 32'd9);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 5'd8, 32'h4100 + 32'(4 * i), 32'(i), 0); step();
    end
    drive(1, 0, 1, 5'd8, 32'h4200, 32'h1, 1); step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);

    // Randomized traffic; ready bias alternates to reach both empty and full.
    for (int i = 0; i < 3000; i++) begin
      int unsigned bias;
      logic [4:0]  wn;
      bias = ((i / 250) % 2 == 1) ? 15 : 85;
      wn   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 3) != 0, wn, $urandom, $urandom,
            $urandom_range(0, 99) < bias);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Buffers the retired-instruction writeback trace (pc, register number, write data) produced by the CPU core and presents it to a downstream trace consumer over a valid/ready handshake. It sits directly downstream of the CPU wrapper's debug_wb_* outputs. It decouples the one-record-per-cycle retire stream from a slower or stalling consumer, such as a golden-trace comparator or a UART dumper, and keeps sticky overflow accounting so lost records are never silent.

## Interface
- DEPTH, 16, number of trace entries; must be a power of two, at least 2.
- AW, 4, log2(DEPTH); pointer width.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_pc  in  32  retiring instruction pc (debug_wb_pc).
- in_wen  in  1  register-file write strobe (debug_wb_rf_wen).
- in_wnum  in  5  destination register number.
- in_wdata  in  32  value written.
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry this cycle.
- out_pc  out  32  head entry pc; 0 when out_valid=0.
- out_wnum  out  5  head entry register number; 0 when out_valid=0.
- out_wdata  out  32  head entry data; 0 when out_valid=0.
- count  out  AW+1  entries currently held, 0..DEPTH.
- overflow  out  1  sticky: at least one record dropped since reset.
- drop_cnt  out  16  dropped-record count, saturating at 16'hFFFF.

## Operation
- Capture: capture = in_wen & (in_wnum != 5'd0). Records to r0 are never stored, counted, or treated as drops.
- Pop: pop = out_valid & out_ready.
- Push: push = capture & (count < DEPTH | pop). A full FIFO with a same-cycle pop accepts the new record.
- Drop: drop = capture & (count == DEPTH) & ~pop. On drop, the entry is discarded, overflow is set to 1, and drop_cnt increments unless it is already 16'hFFFF.
- Storage: circular array of DEPTH x 69 bits {pc, wnum, wdata}. The write pointer and read pointer are AW bits and wrap from DEPTH-1 to 0. count is tracked explicitly:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together.
- Ordering: strict FIFO. Records leave in retire order with no reordering or merging.
- Output: first-word-fall-through. out_* show the entry at the read pointer combinationally from the array, ANDed with out_valid. out_valid = (count != 0).
- Flush: next cycle, count=0 and both pointers are 0. Flush has priority over a same-cycle push and pop, so a capture in the flush cycle is discarded. That discard is not a drop: overflow and drop_cnt are unchanged. overflow and drop_cnt are cleared only by reset.
- Reset: every state element is cleared, mid-stream included. Reset has priority over flush, push and pop.

## Timing
- Reset values: out_valid=0, out_pc=0, out_wnum=0, out_wdata=0, count=0, overflow=0, drop_cnt=0.
- Latency: a record captured in cycle N (FIFO empty) appears with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Handshake:
  - out_* are stable while out_valid=1 and out_ready=0.
  - The consumer may hold out_ready high permanently.
  - out_valid never depends combinationally on out_ready.
- Throughput: one push and one pop per cycle sustained. count stays constant under a simultaneous push and pop.
- Boundaries:
  - Empty with pop attempted: out_valid=0, so no pop occurs and count stays 0.
  - Full with capture and no pop: drop.
  - Full with capture and pop: the new record goes to the old head's slot index, and count stays DEPTH.
  - Pointer wrap at DEPTH-1 to 0 causes no bubble.
- overflow and drop_cnt update in the cycle after the drop.

## Test plan
- Reset, then three captures (pc 0xBFC00000/04/08, wnum 1/2/3, wdata 0x11/0x22/0x33) with out_ready=0 -> count=3, out_valid=1, head {0xBFC00000,1,0x11}, stable. Then out_ready=1 for 3 cycles -> records emerge in order and count returns to 0.
- in_wen=1 with in_wnum=0 for 10 cycles -> count stays 0, overflow=0, drop_cnt=0.
- out_ready=0 and 20 consecutive captures with DEPTH=16 -> count=16, overflow=1, drop_cnt=4. Draining yields the first 16 pcs in order.
- FIFO full, capture and out_ready=1 in the same cycle -> count stays 16, drop_cnt unchanged, and the new record emerges last after a full drain.
- Continuous capture with out_ready=1 for 40 cycles -> count stays 1 after the first cycle, outputs lag inputs by exactly one cycle, and pointers wrap twice without loss.
- count=5, overflow=1, then flush together with a capture -> count=0, out_valid=0 next cycle, overflow=1 and drop_cnt unchanged. Asserting reset mid-stream -> all outputs zero the next cycle.
